div_clk_spi_tx: RTL and testbench

- SPI mode-0 serial transmitter that consumes the divided clock from the clock divider as a timing reference and serialises parallel words onto sclk/mosi/cs_n.
- Runs entirely in the clk_in domain.
- Detects div_clk edges with a registered edge detector and never clocks flops on div_clk directly.
- Sits between the upstream data source (valid/ready handshake) and the off-chip SPI slave.

---
 rtl/div_clk_spi_tx_pkg.sv | 19 +
 rtl/div_clk_spi_tx_clk_edge_det.sv | 32 +++
 rtl/div_clk_spi_tx.sv | 172 +++++++++++++++++
 tb/tb_div_clk_spi_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_spi_tx_pkg.sv
// Shared definitions for the div_clk-timed SPI transmitter.
// Contents: FSM state encodings (3-bit) and the SPI mode constants (mode 0).
package div_clk_spi_tx_pkg;

    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LEAD  = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_TRAIL = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // SPI mode 0: sclk idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/div_clk_spi_tx_clk_edge_det.sv
// Registered edge detector for a clock-like signal that is synchronous to
// clk_in. Reusable by any consumer of div_clk.
// Ports:
//   clk_in  - system clock
//   rst     - synchronous active-high reset
//   sig     - sampled signal (div_clk)
//   rise_c  - combinational: sig went 0->1 since the previous clk_in edge
//   fall_c  - combinational: sig went 1->0 since the previous clk_in edge
module clk_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic sig,
    output logic rise_c,
    output logic fall_c
);

    logic sig_q;

    // Previous-cycle copy of sig.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    // Mutually exclusive by construction.
    assign rise_c = sig & ~sig_q;
    assign fall_c = ~sig & sig_q;

endmodule

// File: rtl/div_clk_spi_tx.sv
// SPI mode-0 transmitter timed by the divided clock div_clk, running entirely
// in the clk_in domain. Words arrive over a valid/ready handshake and leave on
// sclk/mosi/cs_n.
// Build option: define SPI_TX_LSB_FIRST_EN to shift words out LSB first;
// otherwise MSB first. Timing and handshake are identical in both builds.
// Ports:
//   clk_in   - system clock
//   rst      - synchronous active-high reset
//   div_clk  - divided clock (synchronous to clk_in), used only as a timing reference
//   tx_data  - word to send, sampled on the accept cycle
//   tx_valid - source has a word
//   tx_ready - block can accept a word (IDLE only)
//   sclk     - SPI clock
//   mosi     - SPI serial data
//   cs_n     - active-low chip select
//   busy     - transfer in progress (any state but IDLE)
//   done     - one-cycle pulse at the end of each word
module div_clk_spi_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              div_clk,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done
);

    import div_clk_spi_tx_pkg::*;

    logic rise_c;
    logic fall_c;

    clk_edge_det u_edge_det (
        .clk_in (clk_in),
        .rst    (rst),
        .sig    (div_clk),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    state_t              state_q,  state_nxt;
    logic [DATA_W-1:0]   shreg_q,  shreg_nxt;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_nxt;
    logic                sclk_nxt, mosi_nxt, cs_n_nxt, busy_nxt, done_nxt, tx_ready_nxt;

    logic                accept_c;
    logic                last_c;
    logic [DATA_W-1:0]   shreg_shift_c;
    logic                head_c;
    logic                next_head_c;

    assign accept_c = tx_valid & tx_ready;
    assign last_c   = (bit_cnt_q == CNT_W'(DATA_W - 1));

    // Bit order: head_c is the bit currently on the wire side of the register,
    // next_head_c the one that moves there after a shift.
`ifdef SPI_TX_LSB_FIRST_EN
    assign shreg_shift_c = {1'b0, shreg_q[DATA_W-1:1]};
    assign head_c        = shreg_q[0];
    assign next_head_c   = shreg_q[1];
`else
    assign shreg_shift_c = {shreg_q[DATA_W-2:0], 1'b0};
    assign head_c        = shreg_q[DATA_W-1];
    assign next_head_c   = shreg_q[DATA_W-2];
`endif

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk      <= SPI_CPOL;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_ready  <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            shreg_q   <= shreg_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            sclk      <= sclk_nxt;
            mosi      <= mosi_nxt;
            cs_n      <= cs_n_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            tx_ready  <= tx_ready_nxt;
        end
    end

    // Next-state logic; a stuck div_clk simply leaves the FSM parked.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (accept_c)          state_nxt = ST_LEAD;
            ST_LEAD:  if (fall_c)            state_nxt = ST_SHIFT;
            ST_SHIFT: if (fall_c && last_c)  state_nxt = ST_TRAIL;
            ST_TRAIL: if (rise_c)            state_nxt = ST_DONE;
            ST_DONE:                         state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        shreg_nxt    = shreg_q;
        bit_cnt_nxt  = bit_cnt_q;
        sclk_nxt     = sclk;
        mosi_nxt     = mosi;
        cs_n_nxt     = cs_n;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        tx_ready_nxt = tx_ready;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    shreg_nxt    = tx_data;
                    bit_cnt_nxt  = '0;
                    cs_n_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                    tx_ready_nxt = 1'b0;
                end
            end
            ST_LEAD: begin
                // A rise here is ignored so sclk never pulses before mosi is valid.
                if (fall_c) begin
                    mosi_nxt = head_c;
                end
            end
            ST_SHIFT: begin
                if (rise_c) begin
                    sclk_nxt = 1'b1;
                end
                if (fall_c) begin
                    sclk_nxt = 1'b0;
                    if (!last_c) begin
                        shreg_nxt   = shreg_shift_c;
                        mosi_nxt    = next_head_c;
                        bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_TRAIL: begin
                if (rise_c) begin
                    cs_n_nxt = 1'b1;
                    mosi_nxt = 1'b0;
                    done_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                busy_nxt     = 1'b0;
                tx_ready_nxt = 1'b1;
            end
            default: begin
                sclk_nxt     = SPI_CPOL;
                mosi_nxt     = 1'b0;
                cs_n_nxt     = 1'b1;
                busy_nxt     = 1'b0;
                tx_ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_div_clk_spi_tx.sv
// Directed bench for div_clk_spi_tx: DATA_W=8, div_clk period of 5 clk_in
// cycles (2 high, 3 low). Inputs are driven on the falling edge; a monitor
// samples DUT outputs 1 time unit after each rising edge.
module tb_div_clk_spi_tx;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       div_clk = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, sclk, mosi, cs_n, busy, done;

    int total = 0;
    int bad = 0;

    bit div_en = 1'b1;
    int div_cnt = 0;

    int          rise_cnt = 0;
    int          done_cnt = 0;
    int          cs_rise_cnt = 0;
    int          cs_bad = 0;
    logic [63:0] rx = '0;
    logic        sclk_prev = 1'b0;
    logic        cs_prev = 1'b1;

    div_clk_spi_tx #(.DATA_W(8), .CNT_W(5)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .div_clk  (div_clk),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    // Divider model: registered-looking div_clk, changes shortly after posedge.
    always @(posedge clk_in) begin
        #2;
        if (!div_en) begin
            div_cnt = 0;
            div_clk = 1'b0;
        end else begin
            div_cnt = (div_cnt == 4) ? 0 : div_cnt + 1;
            div_clk = (div_cnt < 2);
        end
    end

    // Monitor: capture mosi at each sclk rise, count done pulses and cs_n releases.
    always @(posedge clk_in) begin
        #1;
        if (sclk && !sclk_prev) begin
            rise_cnt = rise_cnt + 1;
            rx = {rx[62:0], mosi};
            if (cs_n) cs_bad = cs_bad + 1;
        end
        if (done) done_cnt = done_cnt + 1;
        if (cs_n && !cs_prev) cs_rise_cnt = cs_rise_cnt + 1;
        sclk_prev = sclk;
        cs_prev = cs_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected capture order of a word at the sclk rises (first bit in MSB).
    function automatic logic [7:0] wire_order(input logic [7:0] w);
        logic [7:0] r;
`ifdef SPI_TX_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
        r = w;
`endif
        return r;
    endfunction

    // Offer a word; returns on the falling edge after the accept edge.
    task automatic send(input logic [7:0] w, input bit hold);
        int n;
        n = 0;
        @(negedge clk_in);
        tx_data = w;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk_in);
        if (!hold) tx_valid = 1'b0;
        check("acc_cs_n", 32'(cs_n), 32'd0);
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_ready", 32'(tx_ready), 32'd0);
    endtask

    // Wait for done; checks the done cycle and the IDLE cycle that follows.
    task automatic wait_done();
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 300) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_ready", 32'(tx_ready), 32'd0);
            check("done_busy", 32'(busy), 32'd1);
            check("done_cs_n", 32'(cs_n), 32'd1);
            @(negedge clk_in);
            check("post_done", 32'(done), 32'd0);
            check("post_ready", 32'(tx_ready), 32'd1);
            check("post_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sclk"}, 32'(sclk), 32'd0);
        check({tag, "_mosi"}, 32'(mosi), 32'd0);
        check({tag, "_cs_n"}, 32'(cs_n), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
    endtask

    int rb, db, cb, n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_in);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk_in);

        // 0xA5 single word
        rb = rise_cnt; db = done_cnt; cb = cs_bad;
        send(8'hA5, 1'b0);
        wait_done();
        check("a5_rises", 32'(rise_cnt - rb), 32'd8);
        check("a5_bits", 32'(rx[7:0]), 32'(wire_order(8'hA5)));
        check("a5_cs_low", 32'(cs_bad - cb), 32'd0);
        check("a5_done_cnt", 32'(done_cnt - db), 32'd1);

        // Bit order: 0x01
        rb = rise_cnt;
        send(8'h01, 1'b0);
        wait_done();
        check("x01_rises", 32'(rise_cnt - rb), 32'd8);
        check("x01_bits", 32'(rx[7:0]), 32'(wire_order(8'h01)));

        // Back-to-back with tx_valid held: 0x3C then 0xFF
        rb = rise_cnt; db = done_cnt; cb = cs_rise_cnt;
        send(8'h3C, 1'b1);
        tx_data = 8'hFF;
        wait_done();
        @(negedge clk_in);
        check("b2b_second_acc", 32'(cs_n), 32'd0);
        check("b2b_second_ready", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        wait_done();
        check("b2b_rises", 32'(rise_cnt - rb), 32'd16);
        check("b2b_bits", 32'(rx[15:0]), 32'({wire_order(8'h3C), wire_order(8'hFF)}));
        check("b2b_cs_release", 32'(cs_rise_cnt - cb), 32'd2);
        check("b2b_done_cnt", 32'(done_cnt - db), 32'd2);

        // Reset after the 3rd sclk rise
        rb = rise_cnt; db = done_cnt;
        send(8'hA5, 1'b0);
        n = 0;
        while ((rise_cnt - rb) < 3 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        check("rst_reach3", 32'(rise_cnt - rb), 32'd3);
        rst = 1'b1;
        @(negedge clk_in);
        check_idle_outputs("midrst");
        rst = 1'b0;
        repeat (40) @(negedge clk_in);
        check("midrst_no_done", 32'(done_cnt - db), 32'd0);
        rb = rise_cnt;
        send(8'h81, 1'b0);
        wait_done();
        check("x81_rises", 32'(rise_cnt - rb), 32'd8);
        check("x81_bits", 32'(rx[7:0]), 32'(wire_order(8'h81)));

        // div_clk stuck low after accept
        n = 0;
        while (div_clk && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        div_en = 1'b0;
        repeat (3) @(negedge clk_in);
        rb = rise_cnt;
        send(8'h5A, 1'b0);
        repeat (40) @(negedge clk_in);
        check("stuck_cs_n", 32'(cs_n), 32'd0);
        check("stuck_sclk", 32'(sclk), 32'd0);
        check("stuck_busy", 32'(busy), 32'd1);
        check("stuck_rises", 32'(rise_cnt - rb), 32'd0);
        div_en = 1'b1;
        wait_done();
        check("stuck_resume_rises", 32'(rise_cnt - rb), 32'd8);
        check("stuck_resume_bits", 32'(rx[7:0]), 32'(wire_order(8'h5A)));

        // Accept coincident with a div_clk rise
        n = 0;
        @(negedge clk_in);
        while (!(div_clk && div_cnt == 0) && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check("phase_found", 32'(n < 20), 32'd1);
        rb = rise_cnt;
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        check("phase_cs_n", 32'(cs_n), 32'd0);
        check("phase_sclk0", 32'(sclk), 32'd0);
        @(negedge clk_in);
        check("phase_sclk1", 32'(sclk), 32'd0);
        wait_done();
        check("phase_rises", 32'(rise_cnt - rb), 32'd8);
        check("phase_bits", 32'(rx[7:0]), 32'(wire_order(8'hC3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
